// File: rtl/mem_stage_access_unit.sv
// ============================================================================
// Module      : mem_stage_access_unit
// Description : MEM-stage data-memory access unit. Issues req/ack memory
//               transactions, stalls the pipeline while an access is pending,
//               and holds the MEM/WB pipeline register.
//               Optional misaligned-access trap enabled by MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_shouldWriteRegister,
    input  logic [4:0]  mem_registerWriteAddress,
    input  logic        mem_shouldWriteMemoryElseAluOutputToRegister,
    input  logic [31:0] mem_aluOutput,
    input  logic        mem_shouldWriteMemory,
    input  logic [31:0] mem_registerRtOrZero,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_shouldWriteRegister,
    output logic [4:0]  wb_registerWriteAddress,
    output logic [31:0] wb_registerWriteData,
    output logic        busError,
    output logic        misaligned
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] C_TIMEOUT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_timeout_count;

    logic w_is_store;
    logic w_is_load;
    logic w_op;
    logic w_trap;
    logic w_start;
    logic w_timeout_hit;

    // Store takes priority when both load and store controls are set.
    assign w_is_store = mem_shouldWriteMemory;
    assign w_is_load  = mem_shouldWriteMemoryElseAluOutputToRegister & ~mem_shouldWriteMemory;
    assign w_op       = mem_shouldWriteMemoryElseAluOutputToRegister | mem_shouldWriteMemory;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = (r_state == IDLE) & w_op & (mem_aluOutput[1:0] != 2'b00);
`else
    assign w_trap = 1'b0;
`endif

    assign w_start       = (r_state == IDLE) & w_op & ~w_trap;
    assign w_timeout_hit = (TIMEOUT_CYCLES != 0) & (r_state == ACCESS) & ~dmem_ack
                           & (r_timeout_count == C_TIMEOUT_LAST);

    assign stall = w_start | ((r_state == ACCESS) & ~dmem_ack & ~w_timeout_hit);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = ACCESS;
            ACCESS:  if (dmem_ack || w_timeout_hit) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_timeout_count <= '0;
        end else begin
            r_state <= w_state_next;
            // Counts ACCESS cycles spent waiting; cleared whenever the access ends.
            if ((r_state == ACCESS) && (w_state_next == ACCESS))
                r_timeout_count <= r_timeout_count + 1'b1;
            else
                r_timeout_count <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            busError   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            busError   <= w_timeout_hit;
            misaligned <= w_trap;
            if (w_start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= w_is_store;
                dmem_addr  <= {mem_aluOutput[31:2], 2'b00};
                dmem_wdata <= mem_registerRtOrZero;
            end else if ((r_state == ACCESS) && (dmem_ack || w_timeout_hit)) begin
                dmem_req <= 1'b0;
            end
        end
    end

    // A stalled cycle inserts a bubble so the held instruction writes back once.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_shouldWriteRegister  <= 1'b0;
            wb_registerWriteAddress <= '0;
            wb_registerWriteData    <= '0;
        end else if (stall) begin
            wb_shouldWriteRegister <= 1'b0;
        end else begin
            wb_shouldWriteRegister  <= mem_shouldWriteRegister & ~w_is_store & ~w_trap & ~w_timeout_hit;
            wb_registerWriteAddress <= mem_registerWriteAddress;
            wb_registerWriteData    <= w_is_load ? dmem_rdata : mem_aluOutput;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_access_unit.sv
// ============================================================================
// Module      : tb_mem_stage_access_unit
// Description : Self-checking bench for mem_stage_access_unit using a
//               per-instruction timeline model. Honours MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_access_unit;

    localparam int T = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_shouldWriteRegister = 1'b0;
    logic [4:0]  mem_registerWriteAddress = '0;
    logic        mem_shouldWriteMemoryElseAluOutputToRegister = 1'b0;
    logic [31:0] mem_aluOutput = '0;
    logic        mem_shouldWriteMemory = 1'b0;
    logic [31:0] mem_registerRtOrZero = '0;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_shouldWriteRegister;
    logic [4:0]  wb_registerWriteAddress;
    logic [31:0] wb_registerWriteData;
    logic        busError;
    logic        misaligned;

    mem_stage_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clock                                        (clock),
        .reset                                        (reset),
        .mem_shouldWriteRegister                      (mem_shouldWriteRegister),
        .mem_registerWriteAddress                     (mem_registerWriteAddress),
        .mem_shouldWriteMemoryElseAluOutputToRegister (mem_shouldWriteMemoryElseAluOutputToRegister),
        .mem_aluOutput                                (mem_aluOutput),
        .mem_shouldWriteMemory                        (mem_shouldWriteMemory),
        .mem_registerRtOrZero                         (mem_registerRtOrZero),
        .stall                                        (stall),
        .dmem_req                                     (dmem_req),
        .dmem_we                                      (dmem_we),
        .dmem_addr                                    (dmem_addr),
        .dmem_wdata                                   (dmem_wdata),
        .dmem_ack                                     (dmem_ack),
        .dmem_rdata                                   (dmem_rdata),
        .wb_shouldWriteRegister                       (wb_shouldWriteRegister),
        .wb_registerWriteAddress                      (wb_registerWriteAddress),
        .wb_registerWriteData                         (wb_registerWriteData),
        .busError                                     (busError),
        .misaligned                                   (misaligned)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Write-back / pulse results the model expects to see one cycle after an instruction retires.
    logic        pend_we   = 1'b0;
    logic [4:0]  pend_addr = '0;
    logic [31:0] pend_data = '0;
    logic        pend_bus  = 1'b0;
    logic        pend_mis  = 1'b0;

    int          stall_cnt;
    int          req_cnt;
    logic        seen_we;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one EX/MEM instruction until it retires. The memory waits wait_cycles ACCESS
    // cycles before acking; first_ack drives dmem_ack in the issue cycle (must be ignored).
    task automatic run_instr(input logic ld, input logic st, input logic rw,
                             input logic [4:0] ra, input logic [31:0] alu,
                             input logic [31:0] wd, input int wait_cycles,
                             input logic [31:0] ack_rdata, input logic first_ack);
        logic mem, trap, is_load, timeout, exp_req, exp_wbwe, finished;
        int   last;
        mem     = ld | st;
        is_load = ld & ~st;
        trap    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap    = mem && (alu[1:0] != 2'b00);
`endif
        timeout = (T != 0) && (wait_cycles + 1 > T);
        last    = timeout ? T : wait_cycles + 1;
        stall_cnt = 0;
        req_cnt   = 0;
        seen_we = 1'b0; seen_addr = '0; seen_wdata = '0;

        mem_shouldWriteRegister                      = rw;
        mem_registerWriteAddress                     = ra;
        mem_shouldWriteMemoryElseAluOutputToRegister = ld;
        mem_aluOutput                                = alu;
        mem_shouldWriteMemory                        = st;
        mem_registerRtOrZero                         = wd;

        for (int t = 0; t < 200; t++) begin
            if (t == 0) dmem_ack = first_ack;
            else        dmem_ack = mem && !trap && !timeout && (t == last);
            dmem_rdata = (dmem_ack && t != 0) ? ack_rdata : $urandom;
            @(negedge clock);

            if (stall) stall_cnt++;
            if (dmem_req) begin
                req_cnt++;
                seen_we = dmem_we; seen_addr = dmem_addr; seen_wdata = dmem_wdata;
            end

            chk("stall", {31'b0, stall}, {31'b0, (t == 0) ? (mem && !trap) : (t < last)});
            exp_req = mem && !trap && (t >= 1);
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, exp_req});
            if (exp_req) begin
                chk("dmem_addr", dmem_addr, {alu[31:2], 2'b00});
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, st});
                chk("dmem_wdata", dmem_wdata, wd);
            end
            exp_wbwe = (t == 0) ? pend_we : 1'b0;
            chk("wb_we", {31'b0, wb_shouldWriteRegister}, {31'b0, exp_wbwe});
            if (exp_wbwe) begin
                chk("wb_addr", {27'b0, wb_registerWriteAddress}, {27'b0, pend_addr});
                chk("wb_data", wb_registerWriteData, pend_data);
            end
            chk("busError", {31'b0, busError}, {31'b0, (t == 0) ? pend_bus : 1'b0});
            chk("misaligned", {31'b0, misaligned}, {31'b0, (t == 0) ? pend_mis : 1'b0});

            finished = (t == 0) ? (!mem || trap) : (t == last);
            if (finished) begin
                pend_we   = rw && !st && !trap && !(mem && timeout);
                pend_addr = ra;
                pend_data = is_load ? dmem_rdata : alu;
                pend_bus  = mem && !trap && timeout;
                pend_mis  = trap;
            end
            @(posedge clock);
            #1;
            if (finished) break;
        end
        dmem_ack = 1'b0;
    endtask

    task automatic set_bubble();
        mem_shouldWriteRegister                      = 1'b0;
        mem_registerWriteAddress                     = '0;
        mem_shouldWriteMemoryElseAluOutputToRegister = 1'b0;
        mem_aluOutput                                = '0;
        mem_shouldWriteMemory                        = 1'b0;
        mem_registerRtOrZero                         = '0;
    endtask

    initial begin
        logic        ld, st, rw;
        logic [31:0] alu;
        int          kind, w;

        set_bubble();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_req", {31'b0, dmem_req}, 32'h0);
        chk("reset_addr", dmem_addr, 32'h0);
        chk("reset_wbwe", {31'b0, wb_shouldWriteRegister}, 32'h0);
        chk("reset_wbdata", wb_registerWriteData, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // ALU result straight to r5 with no stall.
        run_instr(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0, 0, 32'h0, 1'b0);
        chk("lit_alu_stall", stall_cnt, 0);
        chk("lit_alu_wbwe", {31'b0, wb_shouldWriteRegister}, 32'h1);
        chk("lit_alu_wbaddr", {27'b0, wb_registerWriteAddress}, 32'd5);
        chk("lit_alu_wbdata", wb_registerWriteData, 32'h1234);

        // Load with three wait cycles before the ack: four stall cycles, four request cycles.
        run_instr(1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0, 3, 32'hCAFEF00D, 1'b0);
        chk("lit_ld_stall", stall_cnt, 4);
        chk("lit_ld_req", req_cnt, 4);
        chk("lit_ld_addr", seen_addr, 32'h100);
        chk("lit_ld_wbdata", wb_registerWriteData, 32'hCAFEF00D);
        chk("lit_ld_wbwe", {31'b0, wb_shouldWriteRegister}, 32'h1);

        run_instr(1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'hA5A5A5A5, 0, 32'h0, 1'b0);
        chk("lit_st_we", {31'b0, seen_we}, 32'h1);
        chk("lit_st_wdata", seen_wdata, 32'hA5A5A5A5);
        chk("lit_st_wbwe", {31'b0, wb_shouldWriteRegister}, 32'h0);

        // Load that never acks; the next issue cycle carries a late ack.
        run_instr(1'b1, 1'b0, 1'b1, 5'd9, 32'h40, 32'h0, 1000, 32'h0, 1'b0);
        chk("lit_to_req", req_cnt, T);
        chk("lit_to_bus", {31'b0, busError}, 32'h1);
        chk("lit_to_wbwe", {31'b0, wb_shouldWriteRegister}, 32'h0);
        run_instr(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 0, 32'h0, 1'b1);

        run_instr(1'b1, 1'b0, 1'b1, 5'd3, 32'h102, 32'h0, 0, 32'h11, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("lit_mis_req", req_cnt, 0);
        chk("lit_mis_stall", stall_cnt, 0);
        chk("lit_mis_pulse", {31'b0, misaligned}, 32'h1);
`else
        chk("lit_mis_req", req_cnt, 1);
        chk("lit_mis_addr", seen_addr, 32'h100);
        chk("lit_mis_pulse", {31'b0, misaligned}, 32'h0);
`endif

        // Reset in the middle of an outstanding access.
        mem_shouldWriteMemoryElseAluOutputToRegister = 1'b1;
        mem_shouldWriteRegister = 1'b1;
        mem_aluOutput = 32'h200;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        set_bubble();
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_mid_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_mid_stall", {31'b0, stall}, 32'h0);
        chk("rst_mid_wbwe", {31'b0, wb_shouldWriteRegister}, 32'h0);
        chk("rst_mid_bus", {31'b0, busError}, 32'h0);
        dmem_ack = 1'b1;
        @(posedge clock);
        #1;
        dmem_ack = 1'b0;
        chk("rst_late_ack", {31'b0, dmem_req}, 32'h0);
        pend_we = 1'b0; pend_bus = 1'b0; pend_mis = 1'b0;
        run_instr(1'b1, 1'b0, 1'b1, 5'd12, 32'h300, 32'h0, 1, 32'h5555AAAA, 1'b0);
        chk("rst_after_wbdata", wb_registerWriteData, 32'h5555AAAA);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 3);
            ld = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
            st = (kind == 3);
            rw = (kind == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            alu = $urandom;
            if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
            if (kind == 0) alu = '0;
            w = ($urandom_range(0, 7) == 0) ? T + 4 : $urandom_range(0, 4);
            run_instr(ld, st, rw, 5'($urandom), alu, $urandom, w, $urandom,
                      1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
